// File: rtl/rx_serial_param_uart.sv
// Parametrised oversampling UART receiver with false-start rejection, framing/overrun flags and ack-held data.
// Optional build macro MAJORITY_VOTE_EN: each bit decision is a 3-tick majority of the synchronised line.
`timescale 1ns/1ps
module rx_serial_param_uart #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RX,
    input  logic                 tick,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] dado,
    output logic                 pronto,
    output logic                 erro_paridade,
    output logic                 erro_parada,
    output logic                 overrun,
    output logic [3:0]           db_estado
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        INICIO      = 4'd1,
        DADOS       = 4'd2,
        PARIDADE    = 4'd3,
        PARADA      = 4'd4,
        REGISTRA    = 4'd5,
        ESPERA_ALTO = 4'd6
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rxs;
    logic                   bit_val;
    logic [CW-1:0]          tick_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err;
    logic                   stop_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

`ifdef MAJORITY_VOTE_EN
    // History holds rxs at the two previous ticks; the vote closes on the current tick.
    logic [1:0] vote_hist;

    always_ff @(posedge clock) begin
        if (reset)
            vote_hist <= 2'b11;
        else if (tick)
            vote_hist <= {vote_hist[0], rxs};
    end

    assign bit_val = (vote_hist[1] & vote_hist[0]) | (vote_hist[1] & rxs) | (vote_hist[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= INICIAL;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_err       <= 1'b0;
            stop_err      <= 1'b0;
            dado          <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_parada   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (ack) begin
                pronto  <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                INICIAL: begin
                    if (tick && !rxs) begin
                        tick_cnt <= '0;
                        state    <= INICIO;
                    end
                end
                INICIO: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            par_err  <= 1'b0;
                            stop_err <= 1'b0;
                            state    <= bit_val ? INICIAL : DADOS;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DADOS: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? PARIDADE : PARADA;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                PARIDADE: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            par_err  <= (PARITY == 1) ? ~(^{shreg, bit_val}) : (^{shreg, bit_val});
                            state    <= PARADA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                PARADA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            if (!bit_val)
                                stop_err <= 1'b1;
                            if (bit_cnt == LAST_STOP)
                                state <= REGISTRA;
                            else
                                bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                REGISTRA: begin
                    // Registration overrides a simultaneous ack: the new word stays pending.
                    dado          <= shreg;
                    erro_paridade <= (PARITY != 0) ? par_err : 1'b0;
                    erro_parada   <= stop_err;
                    pronto        <= 1'b1;
                    if (pronto && !ack)
                        overrun <= 1'b1;
                    state <= stop_err ? ESPERA_ALTO : INICIAL;
                end
                ESPERA_ALTO: begin
                    if (tick && rxs)
                        state <= INICIAL;
                end
                default: state <= INICIAL;
            endcase
        end
    end

    always_comb begin
        db_estado = 4'hE;
        case (state)
            INICIAL, INICIO, DADOS, PARIDADE, PARADA, REGISTRA, ESPERA_ALTO: db_estado = state;
            default: db_estado = 4'hE;
        endcase
    end

endmodule

// File: tb/tb_rx_serial_param_uart.sv
// Directed bench for rx_serial_param_uart: an 8N1 instance and an 8E1 instance on separate lines.
`timescale 1ns/1ps
module tb_rx_serial_param_uart;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxBit;
    logic       tick;
    logic       ack;
    int         target;
    logic       rxA;
    logic       rxB;

    logic [7:0] dadoA, dadoB;
    logic       prontoA, prontoB;
    logic       parA, parB;
    logic       stopA, stopB;
    logic       ovrA, ovrB;
    logic [3:0] dbA, dbB;

    int          passCount  = 0;
    int          checkCount = 0;
    logic [31:0] seqA;
    logic [3:0]  lastDb     = 4'd0;

    assign rxA = (target == 0) ? rxBit : 1'b1;
    assign rxB = (target == 1) ? rxBit : 1'b1;

    rx_serial_param_uart dutA (
        .clock(clock), .reset(reset), .RX(rxA), .tick(tick), .ack(ack),
        .dado(dadoA), .pronto(prontoA), .erro_paridade(parA), .erro_parada(stopA),
        .overrun(ovrA), .db_estado(dbA)
    );

    rx_serial_param_uart #(.PARITY(2)) dutB (
        .clock(clock), .reset(reset), .RX(rxB), .tick(tick), .ack(ack),
        .dado(dadoB), .pronto(prontoB), .erro_paridade(parB), .erro_parada(stopB),
        .overrun(ovrB), .db_estado(dbB)
    );

    always #5 clock = ~clock;

    // One tick every four clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
        end
    end

    // Records every change of dutA's state code as a nibble stream.
    always @(negedge clock) begin
        if (dbA !== lastDb) begin
            seqA   = {seqA[27:0], dbA};
            lastDb = dbA;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clock);
            while (tick !== 1'b1) @(posedge clock);
        end
        #1;
    endtask

    task automatic applyStimulus(input logic b);
        rxBit = b;
        waitTicks(16);
    endtask

    task automatic sendFrame(input logic [7:0] data, input bit withPar, input logic parBit, input logic stopBit);
        waitTicks(1);
        applyStimulus(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(data[i]);
        if (withPar) applyStimulus(parBit);
        applyStimulus(stopBit);
        rxBit = 1'b1;
    endtask

    task automatic pulseAck();
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic ackInRegistra();
        int n = 0;
        @(negedge clock);
        while (dbA !== 4'd5 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("registraSeen", {28'd0, dbA}, 32'd5);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        rxBit  = 1'b1;
        ack    = 1'b0;
        target = 0;
        seqA   = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("resetDb", {28'd0, dbA}, 32'd0);
        checkOutput("resetDado", {24'd0, dadoA}, 32'd0);
        checkOutput("resetFlags", {28'd0, prontoA, parA, stopA, ovrA}, 32'd0);

        // 8N1 frame 0xA5
        seqA = 32'd0;
        sendFrame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("a5Dado", {24'd0, dadoA}, 32'hA5);
        checkOutput("a5Flags", {28'd0, prontoA, parA, stopA, ovrA}, 32'b1000);
        checkOutput("a5StateSeq", seqA, 32'h0001_2450);
        pulseAck();
        checkOutput("a5AckPronto", {31'd0, prontoA}, 32'd0);

        // Even parity instance: 0x07 has three ones, so parity bit 0 is wrong
        target = 1;
        sendFrame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("parBadFlag", {31'd0, parB}, 32'd1);
        checkOutput("parBadPronto", {31'd0, prontoB}, 32'd1);
        checkOutput("parBadDado", {24'd0, dadoB}, 32'h07);
        pulseAck();
        sendFrame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("parGoodFlag", {31'd0, parB}, 32'd0);
        checkOutput("parGoodDado", {24'd0, dadoB}, 32'h07);
        checkOutput("parGoodStop", {31'd0, stopB}, 32'd0);
        pulseAck();
        target = 0;

        // False start: 5 ticks low is shorter than the half-bit check
        waitTicks(1);
        seqA  = 32'd0;
        rxBit = 1'b0;
        waitTicks(5);
        rxBit = 1'b1;
        waitTicks(20);
        checkOutput("falseStartSeq", seqA, 32'h10);
        checkOutput("falseStartFlags", {28'd0, prontoA, parA, stopA, ovrA}, 32'd0);
        checkOutput("falseStartDado", {24'd0, dadoA}, 32'hA5);

        // Framing error followed by a long break
        waitTicks(1);
        applyStimulus(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(i[0]);
        rxBit = 1'b0;
        waitTicks(30);
        checkOutput("breakState", {28'd0, dbA}, 32'd6);
        waitTicks(10);
        rxBit = 1'b1;
        waitTicks(4);
        checkOutput("breakRelease", {28'd0, dbA}, 32'd0);
        checkOutput("breakStopFlag", {31'd0, stopA}, 32'd1);
        checkOutput("breakDado", {24'd0, dadoA}, 32'hAA);
        checkOutput("breakPronto", {31'd0, prontoA}, 32'd1);
        pulseAck();
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("after3cDado", {24'd0, dadoA}, 32'h3C);
        checkOutput("after3cFlags", {28'd0, prontoA, parA, stopA, ovrA}, 32'b1000);
        pulseAck();

        // Overrun, then ack coinciding with registration
        sendFrame(8'h11, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h22, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("overrunFlag", {31'd0, ovrA}, 32'd1);
        checkOutput("overrunDado", {24'd0, dadoA}, 32'h22);
        pulseAck();
        checkOutput("overrunAck", {30'd0, prontoA, ovrA}, 32'd0);
        checkOutput("overrunAckDado", {24'd0, dadoA}, 32'h22);
        sendFrame(8'h44, 1'b0, 1'b0, 1'b1);
        fork
            sendFrame(8'h55, 1'b0, 1'b0, 1'b1);
            ackInRegistra();
        join
        repeat (2) @(negedge clock);
        checkOutput("ackRegPronto", {30'd0, prontoA, ovrA}, 32'b10);
        checkOutput("ackRegDado", {24'd0, dadoA}, 32'h55);

        // Reset in the middle of the data bits
        waitTicks(1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("preResetState", {28'd0, dbA}, 32'd2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rxBit = 1'b1;
        checkOutput("midResetDb", {28'd0, dbA}, 32'd0);
        checkOutput("midResetDado", {24'd0, dadoA}, 32'd0);
        checkOutput("midResetFlags", {28'd0, prontoA, parA, stopA, ovrA}, 32'd0);
        waitTicks(20);
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        checkOutput("after5aDado", {24'd0, dadoA}, 32'h5A);
        checkOutput("after5aFlags", {28'd0, prontoA, parA, stopA, ovrA}, 32'b1000);
        pulseAck();

`ifdef MAJORITY_VOTE_EN
        // One-tick high glitch on the sample tick of bit 3 of an all-zero word
        waitTicks(1);
        applyStimulus(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rxBit = 1'b0;
                waitTicks(8);
                rxBit = 1'b1;
                waitTicks(1);
                rxBit = 1'b0;
                waitTicks(7);
            end else begin
                applyStimulus(1'b0);
            end
        end
        applyStimulus(1'b1);
        repeat (2) @(negedge clock);
        checkOutput("glitchDado", {24'd0, dadoA}, 32'h00);
        pulseAck();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
